// File: rtl/sdm_pkg.sv
// rtl/sdm_pkg.sv - shared states and helpers for the sigma-delta DAC sequencer
package sdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sdm_state_t;

    // Ceiling log2, used for counter and pointer widths
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Mid-scale code of a WIDTH-bit sample: the modulator's zero output
    function automatic logic [63:0] midscale(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sdm_sample_fifo.sv
// rtl/sdm_sample_fifo.sv - small synchronous sample FIFO with wrap-bit pointers
module sdm_sample_fifo
    import sdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry an extra wrap bit so full and empty differ only in the MSB
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance on accepted push and pop
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdm_dac_sequencer.sv
// rtl/sdm_dac_sequencer.sv - sample scheduler and clock-enable generator for mod2_dac
module sdm_dac_sequencer
    import sdm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int CE_DIV = 4,
    parameter int OSR    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_s_data,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic             o_en,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sample_strobe,
    output logic             o_underrun,
    output logic [1:0]       o_state
);

    localparam int CW = (clog2(CE_DIV) < 1) ? 1 : clog2(CE_DIV);
    localparam int TW = clog2(OSR);
    localparam logic [CW-1:0]    CE_LAST   = CW'(CE_DIV - 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(OSR - 1);
    localparam logic [WIDTH-1:0] MID       = WIDTH'(midscale(WIDTH));

    sdm_state_t       state_q;
    sdm_state_t       state_d;
    logic [CW-1:0]    ce_cnt;
    logic [TW-1:0]    tick_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             boundary;
    logic             load_mid;
    logic             set_under;
    logic             clr_under;
    logic [WIDTH-1:0] head;

    // Ready comes from registered pointers only; forced low while reset is held
    assign o_s_ready = i_rst_n & ~full;
    assign push      = i_s_valid & o_s_ready;
    assign o_en      = (ce_cnt == CE_LAST);
    assign boundary  = o_en && (tick_cnt == TICK_LAST) && (state_q != ST_IDLE);
    assign o_state   = state_q;

    sdm_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (i_s_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Free-running enable divider, active in every state so the modulator idles at mid-scale
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ce_cnt <= '0;
        end else if (o_en) begin
            ce_cnt <= '0;
        end else begin
            ce_cnt <= ce_cnt + 1'b1;
        end
    end

    // Enable-strobe counter; parked at the last tick while idle so the first RUN strobe is a boundary
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
        end else if (state_q == ST_IDLE) begin
            tick_cnt <= TICK_LAST;
        end else if (o_en) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and boundary decisions; stop always wins over start
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_mid  = 1'b0;
        set_under = 1'b0;
        clr_under = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d   = ST_RUN;
                    clr_under = 1'b1;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        set_under = 1'b1;
                    end
                end
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (boundary) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        load_mid = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Modulator sample register, its strobe, and the sticky underrun flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data          <= MID;
            o_sample_strobe <= 1'b0;
            o_underrun      <= 1'b0;
        end else begin
            o_sample_strobe <= pop | load_mid;
            if (pop) begin
                o_data <= head;
            end else if (load_mid) begin
                o_data <= MID;
            end
            if (clr_under) begin
                o_underrun <= 1'b0;
            end else if (set_under) begin
                o_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sdm_dac_sequencer.md
Name: sdm_dac_sequencer

Overview:
- Sample scheduler that sits in front of the 2nd-order sigma-delta DAC (mod2_dac).
- Accepts host samples over a valid/ready stream into a small FIFO and generates the modulator clock-enable strobe.
- Presents one new sample to the modulator every OSR enable ticks.
- Handles start/stop/drain sequencing, mid-scale idling and underrun reporting.

Parameters:
- WIDTH, 8, sample width; equals modulator i_data width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CE_DIV, 4, clocks per modulator enable strobe; at least 1 (1 means o_en is continuously high).
- OSR, 16, enable strobes per sample period; at least 2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset: synchronous, active-low.
- i_start  in  1  one-cycle request to begin playback.
- i_stop  in  1  one-cycle request to drain and stop.
- i_s_data  in  WIDTH  host sample.
- i_s_valid  in  1  host sample valid.
- o_s_ready  out  1  FIFO can accept a sample.
- o_en  out  1  modulator clock enable (drives mod2_dac i_en).
- o_data  out  WIDTH  modulator input sample (drives mod2_dac i_data).
- o_sample_strobe  out  1  one-cycle pulse, aligned with the cycle o_data takes a new value.
- o_underrun  out  1  sticky underrun flag.
- o_state  out  2  current state: IDLE=0, RUN=1, DRAIN=2.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) gives:
  - o_en=0, o_data=MIDSCALE (1<<(WIDTH-1)), o_sample_strobe=0, o_underrun=0, o_state=IDLE;
  - o_s_ready=0 during reset;
  - FIFO emptied; all counters 0.
- Reset mid-operation discards FIFO contents and returns o_data to MIDSCALE on the next clock.
- FIFO:
  - Push when i_s_valid & o_s_ready.
  - o_s_ready = !full, registered-full based, no combinational path from the pop side.
  - Push and pop in the same cycle is legal when not full; occupancy is unchanged.
- Enable divider:
  - ce_cnt runs 0..CE_DIV-1 continuously, in every state, from the first cycle after reset.
  - o_en=1 for exactly the cycle in which ce_cnt==CE_DIV-1, so the modulator keeps running at MIDSCALE while idle.
- Tick counter:
  - tick_cnt counts o_en strobes 0..OSR-1, wraps, and is only active in RUN/DRAIN.
  - Sample boundary = o_en strobe with tick_cnt==OSR-1.
  - On entry to RUN, tick_cnt is preset to OSR-1, so the first boundary is the next o_en strobe.
- Boundary action:
  - FIFO non-empty: pop; o_data <= head, registered, visible the cycle after the boundary; o_sample_strobe=1 in that same cycle.
  - FIFO empty in RUN: o_data holds its last value; o_underrun <= 1; no strobe.
- State machine:
  - IDLE: o_data=MIDSCALE. i_start & !i_stop -> RUN and clear o_underrun. FIFO fills freely while idle.
  - RUN: i_stop -> DRAIN. i_start is ignored.
  - DRAIN:
    - At each boundary, pops while non-empty.
    - At a boundary with the FIFO empty: o_data <= MIDSCALE, o_sample_strobe=1 in the following cycle, -> IDLE.
    - Underrun is not flagged in DRAIN. i_start is ignored.
- Simultaneous i_start and i_stop: stop wins; from IDLE, stay in IDLE.
- Steady-state sample period is CE_DIV*OSR clocks (64 at defaults).
- Widths:
  - ce_cnt is clog2(CE_DIV) wide (min 1); tick_cnt is clog2(OSR) wide.
  - FIFO pointers are clog2(DEPTH)+1 bits wide, with the MSB used to distinguish full from empty.

Decomposition:
- Shared package sdm_pkg:
  - state encodings ST_IDLE/ST_RUN/ST_DRAIN;
  - MIDSCALE function of WIDTH;
  - clog2 helper.
- One sub-module, sdm_sample_fifo:
  - parameterised synchronous FIFO (WIDTH, DEPTH), synchronous active-low reset;
  - ports push/pop/data/full/empty.
- Divider, tick counter and FSM stay in the top.

Test Plan:
- Reset, then 100 idle clocks at defaults -> o_data=8'h80 throughout; o_en pulses every 4th clock; o_state=0; o_s_ready=1 from the cycle after reset release.
- Push 8'h10, 8'h40, 8'hC0, then pulse i_start:
  - o_data sequence is 10, 40, C0, with o_sample_strobe spacing of exactly 64 clocks;
  - first strobe follows the first o_en after start by 1 cycle;
  - o_underrun=0.
- Run with one sample, no further pushes -> at the next boundary o_data holds the value and o_underrun=1; a later i_start from IDLE clears it.
- Fill the FIFO (4 pushes) in IDLE:
  - o_s_ready=0 while full, and a 5th valid is held, not lost;
  - after start, ready returns 1 the cycle after the first pop.
- RUN with 2 queued samples, pulse i_stop:
  - state goes to 2, both samples still play out;
  - the next boundary loads 8'h80 and state returns to 0.
- Pulse i_start and i_stop together in IDLE -> state stays 0. Reset asserted mid-RUN -> next cycle o_data=8'h80, FIFO empty, o_en=0, state 0.
